// File: rtl/arith_pkg.sv
// Shared arithmetic-datapath definitions: FSM state encoding, add/subtract
// mode encodings and the carry-majority helper used by the full-adder cell.
package arith_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  function automatic logic maj3(input logic x, input logic y, input logic z);
    return (x & y) | (x & z) | (y & z);
  endfunction

endpackage

// File: rtl/serial_add_sub_if.sv
// Request/result bundle of the bit-serial adder/subtractor; the requester
// drives operands and Start, the datapath returns status and result.
interface serial_add_sub_if #(
  parameter int WIDTH = 8
);

  logic             Start;
  logic             Mode;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Cin;
  logic             Busy;
  logic             Done;
  logic [WIDTH-1:0] Sum;
  logic             Cout;
  logic             Ovf;

  modport master (
    output Start, Mode, A, B, Cin,
    input  Busy, Done, Sum, Cout, Ovf
  );

  modport slave (
    input  Start, Mode, A, B, Cin,
    output Busy, Done, Sum, Cout, Ovf
  );

endinterface

// File: rtl/fa_cell.sv
// Combinational 1-bit full adder; the single bit-slice of the serial datapath.
module fa_cell
  import arith_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = maj3(a, b, cin);

endmodule

// File: rtl/serial_add_sub.sv
// Bit-serial adder/subtractor: one operand bit per clock, LSB first, through a
// single full-adder cell; result, carry-out and signed overflow on a Done pulse.
module serial_add_sub
  import arith_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  serial_add_sub_if.slave   bus
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t             state_r;
  state_t             state_s;
  logic [WIDTH-1:0]   ra_r;
  logic [WIDTH-1:0]   rb_r;
  logic [WIDTH-2:0]   rs_r;
  logic               c_r;
  logic [CNT_W-1:0]   cnt_r;
  logic [WIDTH-1:0]   sum_r;
  logic               cout_r;
  logic               ovf_r;
  logic               busy_r;
  logic               done_r;

  logic               s_s;
  logic               c_s;
  logic               load_s;
  logic               last_s;
  logic [WIDTH-1:0]   res_s;

  fa_cell u_fa (
    .a    (ra_r[0]),
    .b    (rb_r[0]),
    .cin  (c_r),
    .sum  (s_s),
    .cout (c_s)
  );

  // A new request is taken in IDLE or, for back-to-back issue, in DONE.
  assign load_s = bus.Start && ((state_r == ST_IDLE) || (state_r == ST_DONE));
  assign last_s = (state_r == ST_RUN) && (cnt_r == CNT_W'(WIDTH - 1));
  assign res_s  = {s_s, rs_r};

  // Next-state decode.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.Start) state_s = ST_RUN;
        else           state_s = ST_IDLE;
      end
      ST_RUN: begin
        if (last_s) state_s = ST_DONE;
        else        state_s = ST_RUN;
      end
      ST_DONE: begin
        if (bus.Start) state_s = ST_RUN;
        else           state_s = ST_IDLE;
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // State register plus registered Busy/Done decoded from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      busy_r  <= (state_s == ST_RUN);
      done_r  <= (state_s == ST_DONE);
    end
  end

  // Operand shift registers, carry and bit counter; subtract is A + ~B + ~borrow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ra_r  <= '0;
      rb_r  <= '0;
      rs_r  <= '0;
      c_r   <= 1'b0;
      cnt_r <= '0;
    end else if (load_s) begin
      ra_r  <= bus.A;
      rb_r  <= (bus.Mode == MODE_ADD) ? bus.B : ~bus.B;
      c_r   <= bus.Cin ^ (bus.Mode == MODE_SUB);
      cnt_r <= '0;
    end else if (state_r == ST_RUN) begin
      ra_r  <= ra_r >> 1;
      rb_r  <= rb_r >> 1;
      rs_r  <= res_s[WIDTH-1:1];
      c_r   <= c_s;
      // Hold on the final bit so the counter never wraps inside a run.
      if (!last_s) cnt_r <= cnt_r + CNT_W'(1);
    end
  end

  // Result registers update only on the edge that retires the MSB.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_r  <= '0;
      cout_r <= 1'b0;
      ovf_r  <= 1'b0;
    end else if (last_s) begin
      sum_r  <= res_s;
      cout_r <= c_s;
      ovf_r  <= c_r ^ c_s;
    end
  end

  assign bus.Busy = busy_r;
  assign bus.Done = done_r;
  assign bus.Sum  = sum_r;
  assign bus.Cout = cout_r;
  assign bus.Ovf  = ovf_r;

endmodule

// File: tb/tb_serial_add_sub.sv
// Directed self-checking bench for serial_add_sub at WIDTH=8.
module tb_serial_add_sub;
  import arith_pkg::*;

  localparam int W = 8;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  serial_add_sub_if #(.WIDTH(W)) bus ();

  serial_add_sub #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Presents a request for exactly one rising edge; returns 1 time unit after it.
  task automatic start_op(input logic m, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic ci);
    @(negedge clk);
    bus.Mode  = m;
    bus.A     = a;
    bus.B     = b;
    bus.Cin   = ci;
    bus.Start = 1'b1;
    @(posedge clk);
    #1;
    bus.Start = 1'b0;
  endtask

  // Bounded wait for Done; reports how many edges it took.
  task automatic wait_done(output int edges, output bit seen);
    edges = 0;
    seen  = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(posedge clk);
      #1;
      edges++;
      if (bus.Done === 1'b1) seen = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.Start = 1'b0; bus.Mode = 1'b0; bus.A = '0; bus.B = '0; bus.Cin = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({bus.Busy, bus.Done, bus.Sum, bus.Cout, bus.Ovf} !== 12'h000) begin
      bad++;
      $display("FAIL reset_outputs: got busy=%b done=%b sum=%h cout=%b ovf=%b want all 0",
               bus.Busy, bus.Done, bus.Sum, bus.Cout, bus.Ovf);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_add_basic();
    start_op(MODE_ADD, 8'h3C, 8'h0F, 1'b0);
    total++;
    if (bus.Busy !== 1'b1 || bus.Done !== 1'b0) begin
      bad++;
      $display("FAIL busy_rise: got busy=%b done=%b want busy=1 done=0", bus.Busy, bus.Done);
    end
    for (int e = 1; e <= 7; e++) begin
      @(posedge clk);
      #1;
      total++;
      if (bus.Busy !== 1'b1 || bus.Done !== 1'b0) begin
        bad++;
        $display("FAIL busy_run edge %0d: got busy=%b done=%b want busy=1 done=0",
                 e, bus.Busy, bus.Done);
      end
    end
    @(posedge clk);
    #1;
    total++;
    if (bus.Done !== 1'b1 || bus.Busy !== 1'b0) begin
      bad++;
      $display("FAIL done_latency: got done=%b busy=%b want done=1 busy=0", bus.Done, bus.Busy);
    end
    total++;
    if (bus.Sum !== 8'h4B || bus.Cout !== 1'b0 || bus.Ovf !== 1'b0) begin
      bad++;
      $display("FAIL add_3c_0f: got sum=%h cout=%b ovf=%b want 4b 0 0", bus.Sum, bus.Cout, bus.Ovf);
    end
    @(posedge clk);
    #1;
    total++;
    if (bus.Done !== 1'b0) begin
      bad++;
      $display("FAIL done_one_cycle: got done=%b want 0", bus.Done);
    end
  endtask

  task automatic test_add_carry();
    int edges;
    bit seen;
    start_op(MODE_ADD, 8'hFF, 8'h01, 1'b1);
    wait_done(edges, seen);
    total++;
    if (!seen || edges != 8 || bus.Sum !== 8'h01 || bus.Cout !== 1'b1 || bus.Ovf !== 1'b0) begin
      bad++;
      $display("FAIL add_ff_01_c1: got seen=%0d edges=%0d sum=%h cout=%b ovf=%b want 1 8 01 1 0",
               seen, edges, bus.Sum, bus.Cout, bus.Ovf);
    end
    start_op(MODE_ADD, 8'h7F, 8'h01, 1'b0);
    wait_done(edges, seen);
    total++;
    if (!seen || edges != 8 || bus.Sum !== 8'h80 || bus.Cout !== 1'b0 || bus.Ovf !== 1'b1) begin
      bad++;
      $display("FAIL add_7f_01: got seen=%0d edges=%0d sum=%h cout=%b ovf=%b want 1 8 80 0 1",
               seen, edges, bus.Sum, bus.Cout, bus.Ovf);
    end
  endtask

  task automatic test_sub();
    int edges;
    bit seen;
    start_op(MODE_SUB, 8'h05, 8'h07, 1'b0);
    wait_done(edges, seen);
    total++;
    if (!seen || bus.Sum !== 8'hFE || bus.Cout !== 1'b0 || bus.Ovf !== 1'b0) begin
      bad++;
      $display("FAIL sub_05_07: got seen=%0d sum=%h cout=%b ovf=%b want 1 fe 0 0",
               seen, bus.Sum, bus.Cout, bus.Ovf);
    end
    start_op(MODE_SUB, 8'h80, 8'h01, 1'b0);
    wait_done(edges, seen);
    total++;
    if (!seen || bus.Sum !== 8'h7F || bus.Cout !== 1'b1 || bus.Ovf !== 1'b1) begin
      bad++;
      $display("FAIL sub_80_01: got seen=%0d sum=%h cout=%b ovf=%b want 1 7f 1 1",
               seen, bus.Sum, bus.Cout, bus.Ovf);
    end
    start_op(MODE_SUB, 8'h10, 8'h01, 1'b1);
    wait_done(edges, seen);
    total++;
    if (!seen || bus.Sum !== 8'h0E || bus.Cout !== 1'b1 || bus.Ovf !== 1'b0) begin
      bad++;
      $display("FAIL sub_10_01_b1: got seen=%0d sum=%h cout=%b ovf=%b want 1 0e 1 0",
               seen, bus.Sum, bus.Cout, bus.Ovf);
    end
  endtask

  task automatic test_back_to_back();
    int edges;
    bit seen;
    start_op(MODE_ADD, 8'h01, 8'h01, 1'b0);
    repeat (2) @(posedge clk);
    // Stray request mid-run with different operands must be ignored.
    start_op(MODE_SUB, 8'hAA, 8'h55, 1'b1);
    wait_done(edges, seen);
    total++;
    if (!seen || edges != 5 || bus.Sum !== 8'h02 || bus.Cout !== 1'b0 || bus.Ovf !== 1'b0) begin
      bad++;
      $display("FAIL start_in_run: got seen=%0d edges=%0d sum=%h cout=%b ovf=%b want 1 5 02 0 0",
               seen, edges, bus.Sum, bus.Cout, bus.Ovf);
    end
    // Request presented during the DONE cycle is taken on the next edge.
    bus.Mode = MODE_ADD; bus.A = 8'h12; bus.B = 8'h34; bus.Cin = 1'b0; bus.Start = 1'b1;
    @(posedge clk);
    #1;
    bus.Start = 1'b0;
    total++;
    if (bus.Busy !== 1'b1 || bus.Done !== 1'b0 || bus.Sum !== 8'h02) begin
      bad++;
      $display("FAIL b2b_accept: got busy=%b done=%b sum=%h want 1 0 02", bus.Busy, bus.Done, bus.Sum);
    end
    wait_done(edges, seen);
    total++;
    if (!seen || edges != 8 || bus.Sum !== 8'h46) begin
      bad++;
      $display("FAIL b2b_result: got seen=%0d edges=%0d sum=%h want 1 8 46", seen, edges, bus.Sum);
    end
    @(posedge clk);
    #1;
    total++;
    if (bus.Done !== 1'b0 || bus.Busy !== 1'b0) begin
      bad++;
      $display("FAIL b2b_idle: got done=%b busy=%b want 0 0", bus.Done, bus.Busy);
    end
  endtask

  task automatic test_reset_mid_run();
    int edges;
    bit seen;
    bit stray;
    start_op(MODE_ADD, 8'h20, 8'h30, 1'b0);
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    #2;
    rst = 1'b1;
    #1;
    total++;
    if ({bus.Busy, bus.Done, bus.Sum, bus.Cout, bus.Ovf} !== 12'h000) begin
      bad++;
      $display("FAIL async_reset: got busy=%b done=%b sum=%h cout=%b ovf=%b want all 0",
               bus.Busy, bus.Done, bus.Sum, bus.Cout, bus.Ovf);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    stray = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      if (bus.Done !== 1'b0 || bus.Busy !== 1'b0) stray = 1'b1;
    end
    total++;
    if (stray) begin
      bad++;
      $display("FAIL no_done_after_abort: got activity=1 want 0");
    end
    start_op(MODE_ADD, 8'h11, 8'h22, 1'b1);
    wait_done(edges, seen);
    total++;
    if (!seen || edges != 8 || bus.Sum !== 8'h34 || bus.Cout !== 1'b0 || bus.Ovf !== 1'b0) begin
      bad++;
      $display("FAIL after_reset_op: got seen=%0d edges=%0d sum=%h cout=%b ovf=%b want 1 8 34 0 0",
               seen, edges, bus.Sum, bus.Cout, bus.Ovf);
    end
  endtask

  task automatic test_sum_hold();
    int edges;
    bit seen;
    start_op(MODE_ADD, 8'h3C, 8'h0F, 1'b0);
    wait_done(edges, seen);
    total++;
    if (!seen || bus.Sum !== 8'h4B) begin
      bad++;
      $display("FAIL hold_setup: got seen=%0d sum=%h want 1 4b", seen, bus.Sum);
    end
    start_op(MODE_SUB, 8'h01, 8'h02, 1'b0);
    for (int e = 0; e <= 7; e++) begin
      total++;
      if (bus.Sum !== 8'h4B || bus.Done !== 1'b0) begin
        bad++;
        $display("FAIL sum_hold edge %0d: got sum=%h done=%b want 4b 0", e, bus.Sum, bus.Done);
      end
      @(posedge clk);
      #1;
    end
    total++;
    if (bus.Done !== 1'b1 || bus.Sum !== 8'hFF || bus.Cout !== 1'b0 || bus.Ovf !== 1'b0) begin
      bad++;
      $display("FAIL sum_update: got done=%b sum=%h cout=%b ovf=%b want 1 ff 0 0",
               bus.Done, bus.Sum, bus.Cout, bus.Ovf);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_add_basic();
    test_add_carry();
    test_sub();
    test_back_to_back();
    test_reset_mid_run();
    test_sum_hold();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
